// File: rtl/bytes_to_block.sv
// Packs a stream of IN_W-bit beats, MSB-first, into 128-bit blocks for the AES datapath.
// An assembly register plus an output register keep one beat per clock flowing while the consumer is ready.
module bytes_to_block #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [127:0]    out_data,
    output logic [4:0]      out_nbytes,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int BEATS          = 128 / IN_W;
    localparam int BYTES_PER_BEAT = IN_W / 8;

    logic [127:0] asm_reg;
    logic [4:0]   asm_nbytes;
    logic         asm_full;
    logic [4:0]   cnt;

    logic         accept;
    logic         completing;
    logic         slot_free;
    logic [127:0] beat_ext;
    logic [127:0] asm_next;
    logic [4:0]   blk_nbytes;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready   = ~asm_full;
    assign accept     = in_valid & in_ready;
    assign completing = accept & ((cnt == 5'(BEATS - 1)) | in_last);
    assign slot_free  = ~out_valid | out_ready;

    always_comb begin
        beat_ext              = '0;
        beat_ext[127 -: IN_W] = in_data;
        asm_next              = asm_reg | (beat_ext >> (int'(cnt) * IN_W));
        blk_nbytes            = 5'((int'(cnt) + 1) * BYTES_PER_BEAT);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_reg    <= '0;
            asm_nbytes <= '0;
            asm_full   <= 1'b0;
            cnt        <= '0;
            out_data   <= '0;
            out_nbytes <= '0;
            out_valid  <= 1'b0;
        end else if (clr) begin
            asm_reg    <= '0;
            asm_nbytes <= '0;
            asm_full   <= 1'b0;
            cnt        <= '0;
            out_data   <= '0;
            out_nbytes <= '0;
            out_valid  <= 1'b0;
        end else if (asm_full) begin
            // A stalled block can only exist while out_valid is high; it moves on the first ready cycle.
            if (out_ready) begin
                out_data   <= asm_reg;
                out_nbytes <= asm_nbytes;
                out_valid  <= 1'b1;
                asm_reg    <= '0;
                asm_nbytes <= '0;
                asm_full   <= 1'b0;
                cnt        <= '0;
            end
        end else if (completing) begin
            if (slot_free) begin
                out_data   <= asm_next;
                out_nbytes <= blk_nbytes;
                out_valid  <= 1'b1;
                asm_reg    <= '0;
                cnt        <= '0;
            end else begin
                asm_reg    <= asm_next;
                asm_nbytes <= blk_nbytes;
                asm_full   <= 1'b1;
                cnt        <= '0;
            end
        end else begin
            if (accept) begin
                asm_reg <= asm_next;
                cnt     <= cnt + 5'd1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bytes_to_block.md
Name: bytes_to_block

Overview:
Upstream packer for the AES datapath. Collects a narrow input stream, byte or word at a time, into a 128-bit state block. Presents the block on a valid/ready output, and that output directly feeds the byte-splitting stage. Packing is MSB-first, so the first byte accepted lands in d[127:120], i.e. d00. A two-register arrangement (assembly register plus output register) sustains one input beat per clock while the consumer is ready.

Parameters:
IN_W, 8, input beat width in bits; legal values 8, 16, 32, 64, 128.
BEATS (localparam), 128/IN_W, beats per full block.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; discards any partial assembly and any held output block
in_data  input  IN_W  input beat; the first beat of a block maps to the most significant bits
in_valid  input  1  in_data valid
in_last  input  1  final beat of a message; closes the current block early
in_ready  output  1  block accepts a beat this cycle
out_data  output  128  assembled block
out_nbytes  output  5  valid bytes in out_data, 1..16
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts the block

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_nbytes=0, in_ready=1, assembly register=0, beat count=0, asm_full=0.
- Handshakes:
  - An input beat is accepted when in_valid && in_ready.
  - An output block is consumed when out_valid && out_ready.
- Beat placement: accepted beat k (0-based) is written to asm[127-k*IN_W -: IN_W]; the count increments.
- Completing beat: the beat where k==BEATS-1, or any accepted beat with in_last=1.
  - Unfilled low-order bits are zero.
  - nbytes = (k+1)*IN_W/8.
- Direct transfer: if the output slot is free on the completing-beat cycle (!out_valid || out_ready), the next edge does all of the following:
  - loads out_data and out_nbytes, and sets out_valid=1;
  - clears asm and count.
  - Latency is 1 cycle from the completing beat to out_valid, and in_ready stays high, so a new block may start on the very next cycle.
- Stall: if the output slot is occupied on the completing beat, the block is held in asm and asm_full=1.
  - in_ready = !asm_full, registered so there is no combinational path from out_ready to in_ready.
  - On the first cycle where out_ready=1 while asm_full=1, the next edge moves asm into the output register and clears asm_full and count.
- Output hold: out_valid falls only after a consume with no new block loading on the same edge. out_data and out_nbytes stay stable while out_valid && !out_ready.
- Simultaneous events: consume and load on the same edge gives out_valid staying 1 with the new data and no bubble.
- in_last on a non-completing count: the block closes at the current count, and the next beat starts a new block at beat 0.
- in_last ignored when in_valid=0. in_data ignored when not accepted.
- clr: takes priority over all activity on that edge. It returns every state element to its reset value and drops any beat presented in the same cycle.
- Reset mid-block: partial data is lost, and no output is produced for it.
- IN_W=128: every accepted beat is a completing beat, so the block degenerates to a 1-deep registered slice.

Test Plan:
1. IN_W=8, out_ready=1, bytes 0x00,0x11,...,0xff over 16 cycles -> out_data=00112233445566778899aabbccddeeff and out_nbytes=16, one cycle after the 16th beat; in_ready never drops.
2. IN_W=32, words 00112233, 44556677, 8899aabb, ccddeeff followed immediately by a second block 0f0e0d0c, 0b0a0908, 07060504, 03020100 -> two blocks on back-to-back output transfers; a second check holds out_ready=0 until the second block completes -> asm_full, in_ready=0, first block held stable until out_ready=1.
3. IN_W=8, three bytes a1,b2,c3 with in_last on c3 -> out_data=a1b2c300000000000000000000000000, out_nbytes=3; the next byte starts at d[127:120].
4. Random in_valid and out_ready (50% each), IN_W=8, 200 blocks -> every block compared against a scoreboard; no loss, no duplication, no change of held output.
5. clr asserted after 7 of 16 bytes, and again while out_valid=1 with out_ready=0 -> out_valid=0, count=0; the next 16 bytes form a clean block.
6. rst_n pulsed low asynchronously mid-block, including mid-cycle -> all outputs return to reset values immediately; normal operation resumes after deassertion.
